// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle HI/LO multiply/divide unit for the MIPS datapath. It computes
//   MULT/MULTU with shift-add and DIV/DIVU with restoring division, one bit
//   per cycle. It also handles MTHI/MTLO and owns the architectural HI/LO
//   registers.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     start        issue op (sampled only in IDLE)
//     op[2:0]      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//     rs_content   multiplicand / dividend / MTHI-MTLO source
//     rt_content   multiplier / divisor
//     busy         op in progress; start is ignored while high
//     done         one-cycle pulse; hi/lo already hold the new values
//     div_by_zero  pulses with done when a DIV/DIVU divisor is 0
//     hi, lo       HI/LO registers
//
//   state | meaning
//   IDLE  | waiting for start
//   MUL   | shift-add iterations, multiplier LSB first
//   DIV   | restoring division iterations, quotient MSB first
//   FIX   | apply result signs and write hi/lo
//   DONE  | one-cycle done pulse
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q;
  // For MUL: upper half is the running partial sum, lower half holds the
  // multiplier and is shifted out as product bits are shifted in.
  // For DIV: upper half is the partial remainder, lower half holds the
  // dividend and is shifted out as quotient bits are shifted in.
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opa_q;       // |multiplicand| or |divisor|
  logic                 sign_a_q;    // rs sign (0 for unsigned ops)
  logic                 sign_b_q;    // rt sign (0 for unsigned ops)
  logic                 is_div_q;
  logic                 dbz_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 div_by_zero_q;

  // Operand magnitudes at issue time
  logic                 op_signed;
  logic                 rs_neg;
  logic                 rt_neg;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;

  // One iteration of each algorithm
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_mul_d;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   acc_div_d;

  // Signed fix-up of the raw magnitudes
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign rs_neg    = op_signed & rs_content[WIDTH-1];
  assign rt_neg    = op_signed & rt_content[WIDTH-1];
  assign rs_mag    = rs_neg ? (~rs_content + 1'b1) : rs_content;
  assign rt_mag    = rt_neg ? (~rt_content + 1'b1) : rt_content;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
  assign acc_mul_d = {mul_sum, acc_q[WIDTH-1:1]};

  // The shifted remainder can be one bit wider than the divisor; after a
  // successful subtract it always fits back into WIDTH bits.
  assign div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_sh >= {1'b0, opa_q});
  assign div_diff  = div_sh - {1'b0, opa_q};
  assign acc_div_d = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};

  // MIN / -1 falls out naturally: the magnitude quotient is 2^(WIDTH-1),
  // and negating it mod 2^WIDTH gives MIN again.
  assign prod_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix   = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1)
                                           : acc_q[WIDTH-1:0];
  assign rem_fix   = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                              : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      opa_q         <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      is_div_q      <= 1'b0;
      dbz_q         <= 1'b0;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q        <= 1'b0;
          div_by_zero_q <= 1'b0;
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opa_q    <= rs_mag;
                acc_q    <= {{WIDTH{1'b0}}, rt_mag};
                sign_a_q <= rs_neg;
                sign_b_q <= rt_neg;
                is_div_q <= 1'b0;
                dbz_q    <= 1'b0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                opa_q    <= rt_mag;
                sign_a_q <= rs_neg;
                sign_b_q <= rt_neg;
                is_div_q <= 1'b1;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                if (rt_content == '0) begin
                  // Park |rs| in the remainder half so FIX restores rs into hi.
                  acc_q   <= {rs_mag, {WIDTH{1'b0}}};
                  dbz_q   <= 1'b1;
                  state_q <= S_FIX;
                end else begin
                  acc_q   <= {{WIDTH{1'b0}}, rs_mag};
                  dbz_q   <= 1'b0;
                  state_q <= S_DIV;
                end
              end
              OP_MTHI: begin
                hi_q    <= rs_content;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              OP_MTLO: begin
                lo_q    <= rs_content;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end

        S_MUL: begin
          acc_q <= acc_mul_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end

        S_DIV: begin
          acc_q <= acc_div_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end

        S_FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= dbz_q ? {WIDTH{1'b1}} : quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          div_by_zero_q <= dbz_q;
          state_q       <= S_DONE;
        end

        S_DONE: begin
          done_q        <= 1'b0;
          div_by_zero_q <= 1'b0;
          dbz_q         <= 1'b0;
          state_q       <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
